// File: rtl/dac_fifo_pkg.sv
// dac_fifo_pkg: shared reader FSM state type and default widths for the DAC FIFO reader
package dac_fifo_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, RUN} dac_rd_state_t;
  localparam int DAC_SAMPLE_W = 16;
  localparam int DAC_WORD_W = 32;
endpackage

// File: rtl/dac_fifo_reader_if.sv
// dac_fifo_reader_if: FIFO read port (empty/readdata/read) and DAC port (enable/tick in; data/valid/underrun/count/running out)
interface dac_fifo_reader_if
  import dac_fifo_pkg::*;
#(
  parameter int DATA_W = DAC_WORD_W,
  parameter int SAMPLE_W = DAC_SAMPLE_W,
  parameter int CNT_W = 16
);
  logic enable;
  logic sample_tick;
  logic dacfifo_empty;
  logic [DATA_W-1:0] dacfifo_readdata;
  logic dacfifo_read;
  logic [SAMPLE_W-1:0] dac_data;
  logic dac_valid;
  logic underrun;
  logic [CNT_W-1:0] underrun_count;
  logic running;
  modport master (
    input enable, sample_tick, dacfifo_empty, dacfifo_readdata,
    output dacfifo_read, dac_data, dac_valid, underrun, underrun_count, running
  );
  modport slave (
    output enable, sample_tick, dacfifo_empty, dacfifo_readdata,
    input dacfifo_read, dac_data, dac_valid, underrun, underrun_count, running
  );
endinterface

// File: rtl/dac_word_prefetch.sv
// dac_word_prefetch: word+pend buffers with one-deep FIFO prefetch; in flush/pop_half/fifo_empty/fifo_data, out fifo_read/arrive/avail/sample
module dac_word_prefetch
  import dac_fifo_pkg::*;
#(
  parameter int DATA_W = DAC_WORD_W,
  parameter int SAMPLE_W = DAC_SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                pop_half_i,
  input  logic                fifo_empty_i,
  input  logic [DATA_W-1:0]   fifo_data_i,
  output logic                fifo_read_o,
  output logic                arrive_o,
  output logic                avail_o,
  output logic [SAMPLE_W-1:0] sample_o
);
  logic [DATA_W-1:0] word_q, word_d, pend_q, pend_d;
  logic word_valid_q, word_valid_d, pend_valid_q, pend_valid_d, half_q, half_d;
  logic rd_q, rd_d, ret_q, ret_d, shift, to_word, to_pend;
  always_comb begin
    shift = pop_half_i && half_q;
    to_word = ret_q && (shift ? !pend_valid_q : !word_valid_q);
    to_pend = ret_q && !to_word;
    word_d = to_word ? fifo_data_i : shift ? pend_q : word_q;
    word_valid_d = !flush_i && (to_word || (shift ? pend_valid_q : word_valid_q));
    pend_d = to_pend ? fifo_data_i : pend_q;
    pend_valid_d = !flush_i && (to_pend || (pend_valid_q && !shift));
    half_d = !flush_i && !shift && !to_word && (half_q || pop_half_i);
    rd_d = !flush_i && !fifo_empty_i && !rd_q && !ret_q && !(word_valid_q && pend_valid_q);
    ret_d = rd_q && !flush_i;
  end
  always_ff @(posedge clk) begin
    word_q <= word_d;
    pend_q <= pend_d;
    if (rst) begin
      word_valid_q <= 1'b0;
      pend_valid_q <= 1'b0;
      half_q <= 1'b0;
      rd_q <= 1'b0;
      ret_q <= 1'b0;
    end else begin
      word_valid_q <= word_valid_d;
      pend_valid_q <= pend_valid_d;
      half_q <= half_d;
      rd_q <= rd_d;
      ret_q <= ret_d;
    end
  end
  assign fifo_read_o = rd_q;
  assign arrive_o = ret_q;
  assign avail_o = word_valid_q;
  assign sample_o = half_q ? word_q[DATA_W-1:SAMPLE_W] : word_q[SAMPLE_W-1:0];
endmodule

// File: rtl/dac_fifo_reader.sv
// dac_fifo_reader: splits FIFO words into DAC samples per tick with underrun counting; ports clk, rst, bus (dac_fifo_reader_if.master)
module dac_fifo_reader
  import dac_fifo_pkg::*;
#(
  parameter int DATA_W = DAC_WORD_W,
  parameter int SAMPLE_W = DAC_SAMPLE_W,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  dac_fifo_reader_if.master bus
);
  dac_rd_state_t state_q, state_d;
  logic [SAMPLE_W-1:0] data_q, data_d, sample;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic valid_q, under_q, flush, tick_run, pop, avail, arrive, rd;
  always_comb begin
    state_d = !bus.enable ? IDLE : state_q == IDLE ? PRIME : (state_q == PRIME && arrive) ? RUN : state_q;
    flush = state_d == IDLE;
    tick_run = bus.sample_tick && state_q == RUN && !flush;
    pop = tick_run && avail;
    data_d = flush ? '0 : pop ? sample : tick_run ? '0 : data_q;
    cnt_d = flush ? '0 : (tick_run && !avail && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q <= '0;
      valid_q <= 1'b0;
      under_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      valid_q <= pop;
      under_q <= tick_run && !avail;
      cnt_q <= cnt_d;
    end
  end
  dac_word_prefetch #(.DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W)) u_prefetch (
    .clk(clk),
    .rst(rst),
    .flush_i(flush),
    .pop_half_i(pop),
    .fifo_empty_i(bus.dacfifo_empty),
    .fifo_data_i(bus.dacfifo_readdata),
    .fifo_read_o(rd),
    .arrive_o(arrive),
    .avail_o(avail),
    .sample_o(sample)
  );
  assign bus.dacfifo_read = rd;
  assign bus.dac_data = data_q;
  assign bus.dac_valid = valid_q;
  assign bus.underrun = under_q;
  assign bus.underrun_count = cnt_q;
  assign bus.running = state_q == RUN;
endmodule

// File: doc/dac_fifo_reader.md
# dac_fifo_reader

Read side of the DAC sample FIFO: pops 32-bit words written by the host-side `dacfifo_write`/`dacfifo_writedata` path, splits each word into two 16-bit DAC samples and presents one sample per `sample_tick` to the DAC output stage (the `phaser_0` DDS/DAC datapath). It keeps one word of prefetch so the DAC sees back-to-back samples with no FIFO latency bubble. It detects and counts underruns when the FIFO runs dry mid-stream.

## Interface
- `DATA_W`, 32, FIFO word width; must equal 2*`SAMPLE_W`
- `SAMPLE_W`, 16, DAC sample width
- `CNT_W`, 16, underrun counter width

- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  reset, synchronous, active-high
- `enable`  in  1  stream enable; low = flush and idle
- `sample_tick`  in  1  one-cycle DAC sample strobe; at most one per 2 cycles
- `dacfifo_empty`  in  1  FIFO empty flag
- `dacfifo_readdata`  in  DATA_W  FIFO output, valid the cycle after `dacfifo_read` (standard, non-show-ahead)
- `dacfifo_read`  out  1  FIFO pop request
- `dac_data`  out  SAMPLE_W  sample to DAC, registered
- `dac_valid`  out  1  one-cycle pulse: `dac_data` updated from a real sample
- `underrun`  out  1  one-cycle pulse: tick in RUN with no sample available
- `underrun_count`  out  CNT_W  saturating underrun count, cleared by reset or entering IDLE
- `running`  out  1  high in RUN state

## Operation
- Storage: `word_reg`+`word_valid`+`half` (0 = bits [15:0] next, 1 = bits [31:16] next); `pend_reg`+`pend_valid` prefetch; `rd_inflight` flag.
- Read issue: `dacfifo_read`=1 when state≠IDLE, `!dacfifo_empty`, `!rd_inflight`, and at least one of `word_valid`/`pend_valid` is free, counting the in-flight word. Never pops an empty FIFO.
- Data return (cycle after read): loads `word_reg` if `word_valid`=0 (`half`←0), else `pend_reg`.
- On `sample_tick` with `word_valid`: `dac_data`←selected half, `dac_valid` pulse. If `half`=1, `word_reg`←`pend_reg`, `word_valid`←`pend_valid`, `pend_valid`←0, `half`←0. If the pend slot is empty and a FIFO word returns the same cycle, the returning word goes directly to `word_reg`. Otherwise `half`←1.
- FSM states:
  - IDLE: entered on reset or `enable`=0. All buffers invalid. Returning in-flight data is discarded. `dac_data`←0. No reads issued. Goes to PRIME when `enable`=1.
  - PRIME: reads issued. Ticks output nothing and are not counted. Goes to RUN when `word_valid` becomes 1.
  - RUN: ticks consume samples. A tick with `word_valid`=0 holds `dac_data` at 0, pulses `underrun`, and increments `underrun_count`, saturating at all-ones. RUN stays RUN and resumes with the next returned word, lower half first.
- `enable` falling in any state → IDLE next cycle. Words already popped are dropped by design.
- Reset mid-stream behaves like `enable` falling and also clears `underrun_count`.

## Timing
- Reset values: `dacfifo_read`=0, `dac_data`=0, `dac_valid`=0, `underrun`=0, `underrun_count`=0, `running`=0, state IDLE.
- `dacfifo_read` is registered. Example with `enable` rising at cycle 0 and FIFO non-empty:
  - cycle 1: first read issued
  - cycle 2: data returns
  - cycle 3: `running`=1
  - up to cycle 5: second read/return fills `pend`
- `sample_tick` at cycle t → `dac_data`/`dac_valid`/`underrun` at t+1.
- Sustained throughput: one word per two ticks. With ticks every ≥2 cycles and a non-empty FIFO, no underrun occurs after PRIME.

## Structure
- Package `dac_fifo_pkg`:
  - state enum `dac_rd_state_t` {IDLE, PRIME, RUN}
  - default widths `DAC_SAMPLE_W`=16, `DAC_WORD_W`=32
- One sub-module, `dac_word_prefetch`. It owns `word`/`pend`/`rd_inflight`, read-issue logic and direct-bypass on return, and exposes `pop_half`/`sample`/`avail`.
- Top level holds the FSM, output registers and counter.

## Test plan
- Prime: FIFO holds 0x2222_1111, 0x4444_3333; enable, ticks every 4 cycles → `dac_data` sequence 0x1111, 0x2222, 0x3333, 0x4444, exactly 2 pops, `underrun`=0.
- Underrun: FIFO empties after 1 word, 3 further ticks → 3 `underrun` pulses, `dac_data`=0, `underrun_count`=3. Then push 0xBBBB_AAAA → next tick outputs 0xAAAA.
- Saturation: `CNT_W`=4, 20 ticks with FIFO empty in RUN → `underrun_count`=15.
- Back-to-back: ticks every 2 cycles over 64 words → 128 samples in order, no underrun, no read while `dacfifo_empty`=1.
- Flush: drop `enable` while a read is in flight → IDLE next cycle, returning word discarded, `dac_data`=0, `underrun_count`=0. Re-enable restarts from the next FIFO word.
- Reset mid-RUN: assert `rst` one cycle → all outputs at reset values the following cycle, no `dacfifo_read` until `enable` is seen again.
